// File: rtl/tart_capture_pkg.sv
// Shared definitions for the TART sample capture front end:
// FSM encodings and default timing parameters.
package tart_capture_pkg;

   typedef enum logic [1:0] {
      CAP_UNLOCKED = 2'd0,
      CAP_ACQUIRE  = 2'd1,
      CAP_LOCKED   = 2'd2
   } cap_state_e;

   localparam int unsigned CAP_RATIO    = 12;
   localparam int unsigned CAP_TOL      = 1;
   localparam int unsigned CAP_LOCK_CNT = 16;

endpackage

// File: rtl/tart_sync_edge.sv
// Two-flop synchroniser for rx_clk and rx_dat, plus the delayed-clock
// flop that turns the synchronised clock into a one-cycle rise pulse.
module tart_sync_edge
   import tart_capture_pkg::*;
#(
   parameter int unsigned WIDTH = 24
) (
   input  logic             clk_x,
   input  logic             rst,
   input  logic             rx_clk,
   input  logic [WIDTH-1:0] rx_dat,
   output logic             rise,
   output logic [WIDTH-1:0] s2_dat
);

   logic             s1_clk_d, s1_clk_q;
   logic             s2_clk_d, s2_clk_q;
   logic             c3_d, c3_q;
   logic [WIDTH-1:0] s1_dat_d, s1_dat_q;
   logic [WIDTH-1:0] s2_dat_d, s2_dat_q;

   // Clock and data share the same two stages so they stay aligned.
   always_comb begin
      s1_clk_d = rx_clk;
      s2_clk_d = s1_clk_q;
      c3_d     = s2_clk_q;
      s1_dat_d = rx_dat;
      s2_dat_d = s1_dat_q;
   end

   always_ff @(posedge clk_x) begin
      if (rst) begin
         s1_clk_q <= 1'b0;
         s2_clk_q <= 1'b0;
         c3_q     <= 1'b0;
         s1_dat_q <= '0;
         s2_dat_q <= '0;
      end else begin
         s1_clk_q <= s1_clk_d;
         s2_clk_q <= s2_clk_d;
         c3_q     <= c3_d;
         s1_dat_q <= s1_dat_d;
         s2_dat_q <= s2_dat_d;
      end
   end

   assign rise   = s2_clk_q & ~c3_q;
   assign s2_dat = s2_dat_q;

endmodule

// File: rtl/tart_sample_capture.sv
// Capture stage: locks onto the radio sample period and latches one
// antenna word per period at a programmable phase.
module tart_sample_capture
   import tart_capture_pkg::*;
#(
   parameter int unsigned WIDTH    = 24,
   parameter int unsigned RATIO    = CAP_RATIO,
   parameter int unsigned TOL      = CAP_TOL,
   parameter int unsigned LOCK_CNT = CAP_LOCK_CNT,
   parameter int unsigned DELAY    = 3
) (
   input  logic             clk_x,
   input  logic             rst,
   input  logic             enable,
   input  logic             rx_clk,
   input  logic [WIDTH-1:0] rx_dat,
   input  logic [3:0]       phase,
   output logic             strobe,
   output logic [WIDTH-1:0] antenna,
   output logic             locked,
   output logic [31:0]      sample_count,
   output logic [7:0]       err_count
);

   localparam logic [5:0] MIN_P     = 6'(RATIO - TOL);
   localparam logic [5:0] MAX_P     = 6'(RATIO + TOL);
   localparam logic [4:0] TOUT_PER  = 5'(RATIO + TOL);
   localparam logic [3:0] PH_MAX    = 4'(RATIO - 1);
   localparam logic [4:0] LOCK_LAST = 5'(LOCK_CNT - 1);

   // DELAY is accepted for compatibility; registers update with zero delay.
   if (DELAY > 0) begin : g_zero_delay
   end

   logic             rise;
   logic [WIDTH-1:0] s2_dat;

   tart_sync_edge #(
      .WIDTH (WIDTH)
   ) u_sync (
      .clk_x  (clk_x),
      .rst    (rst),
      .rx_clk (rx_clk),
      .rx_dat (rx_dat),
      .rise   (rise),
      .s2_dat (s2_dat)
   );

   cap_state_e       state_d, state_q;
   logic [4:0]       per_d, per_q;
   logic [4:0]       good_d, good_q;
   logic [7:0]       err_d, err_q;
   logic [31:0]      count_d, count_q;
   logic [WIDTH-1:0] antenna_d, antenna_q;
   logic             strobe_d, strobe_q;
   logic             locked_d, locked_q;

   logic [5:0] meas;
   logic       per_ok;
   logic       timeout;
   logic [3:0] phase_c;
   logic       capture;

   always_comb begin
      meas    = {1'b0, per_q} + 6'd1;
      per_ok  = (meas >= MIN_P) && (meas <= MAX_P);
      timeout = (per_q == TOUT_PER) && !rise;
      phase_c = (phase > PH_MAX) ? PH_MAX : phase;
      capture = (per_q == {1'b0, phase_c}) && !rise;

      per_d     = per_q;
      state_d   = state_q;
      good_d    = good_q;
      err_d     = err_q;
      count_d   = count_q;
      antenna_d = antenna_q;
      strobe_d  = 1'b0;

      if (rise) begin
         per_d = '0;
      end else if (per_q != 5'd31) begin
         per_d = per_q + 5'd1;
      end

      unique case (state_q)
         CAP_UNLOCKED: begin
            if (rise) begin
               state_d = CAP_ACQUIRE;
               good_d  = '0;
            end
         end
         CAP_ACQUIRE: begin
            if (timeout) begin
               state_d = CAP_UNLOCKED;
            end else if (rise && per_ok) begin
               good_d = good_q + 5'd1;
               if (good_q == LOCK_LAST) state_d = CAP_LOCKED;
            end else if (rise) begin
               good_d = '0;
            end
         end
         CAP_LOCKED: begin
            if (timeout || (rise && !per_ok)) begin
               state_d = CAP_UNLOCKED;
               if (err_q != 8'hFF) err_d = err_q + 8'd1;
            end
         end
         default: state_d = CAP_UNLOCKED;
      endcase

      if (capture) begin
         antenna_d = s2_dat;
         strobe_d  = (state_q == CAP_LOCKED) && enable;
      end

      if (strobe_q) count_d = count_q + 32'd1;

      locked_d = (state_d == CAP_LOCKED);
   end

   always_ff @(posedge clk_x) begin
      if (rst) begin
         state_q   <= CAP_UNLOCKED;
         per_q     <= '0;
         good_q    <= '0;
         err_q     <= '0;
         count_q   <= '0;
         antenna_q <= '0;
         strobe_q  <= 1'b0;
         locked_q  <= 1'b0;
      end else begin
         state_q   <= state_d;
         per_q     <= per_d;
         good_q    <= good_d;
         err_q     <= err_d;
         count_q   <= count_d;
         antenna_q <= antenna_d;
         strobe_q  <= strobe_d;
         locked_q  <= locked_d;
      end
   end

   assign strobe       = strobe_q;
   assign antenna      = antenna_q;
   assign locked       = locked_q;
   assign sample_count = count_q;
   assign err_count    = err_q;

endmodule

// File: tb/tb_tart_sample_capture.sv
// Directed bench for tart_sample_capture: rx_clk is driven on clk_x
// falling edges so synchroniser latency is deterministic.
module tb_tart_sample_capture;

   localparam int W = 24;

   logic          clk_x = 1'b0;
   logic          rst;
   logic          enable;
   logic          rx_clk;
   logic [W-1:0]  rx_dat;
   logic [3:0]    phase;
   logic          strobe;
   logic [W-1:0]  antenna;
   logic          locked;
   logic [31:0]   sample_count;
   logic [7:0]    err_count;

   int n_cmp = 0;
   int n_bad = 0;
   int cyc = 0;
   int h_last = 0;
   int h_prev = 0;
   int strobe_cnt = 0;
   int last_strobe_cyc = -1;
   logic [W-1:0] last_ant = '0;

   tart_sample_capture #(
      .WIDTH    (W),
      .RATIO    (12),
      .TOL      (1),
      .LOCK_CNT (16),
      .DELAY    (3)
   ) dut (
      .clk_x        (clk_x),
      .rst          (rst),
      .enable       (enable),
      .rx_clk       (rx_clk),
      .rx_dat       (rx_dat),
      .phase        (phase),
      .strobe       (strobe),
      .antenna      (antenna),
      .locked       (locked),
      .sample_count (sample_count),
      .err_count    (err_count)
   );

   always #5 clk_x = ~clk_x;

   always @(posedge clk_x) cyc <= cyc + 1;

   always @(negedge clk_x) begin
      if (strobe === 1'b1) begin
         strobe_cnt      <= strobe_cnt + 1;
         last_strobe_cyc <= cyc;
         last_ant        <= antenna;
      end
   end

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // One rx_clk period of len clk_x cycles, high for the first half.
   task automatic run_period(input int len, input logic [W-1:0] dat);
      for (int i = 0; i < len; i++) begin
         @(negedge clk_x);
         if (i == 0) begin
            h_prev = h_last;
            h_last = cyc;
         end
         rx_clk = (i < len / 2);
         rx_dat = dat;
      end
   endtask

   function automatic logic [W-1:0] pat(input int k);
      return (k % 2 == 1) ? 24'h5A5A5A : 24'hA5A5A5;
   endfunction

   int sc0, st0, hl;
   logic l16, l17;
   logic [7:0] e17;

   initial begin
      rst = 1'b1;
      enable = 1'b1;
      rx_clk = 1'b0;
      rx_dat = '0;
      phase = 4'd6;
      l16 = 1'bx;
      l17 = 1'bx;
      e17 = 'x;
      repeat (3) @(negedge clk_x);
      chk("rst_strobe", strobe, 0);
      chk("rst_antenna", antenna, 0);
      chk("rst_locked", locked, 0);
      chk("rst_count", sample_count, 0);
      chk("rst_err", err_count, 0);
      rst = 1'b0;

      // Clean lock: first rise unjudged, then 16 good periods.
      for (int k = 0; k < 16; k++) run_period(12, pat(k));
      #1;
      chk("pre_lock", locked, 0);
      run_period(12, pat(16));
      #1;
      chk("lock", locked, 1);
      chk("first_strobe", strobe_cnt, 1);
      for (int k = 17; k < 26; k++) run_period(12, pat(k));
      #1;
      chk("strobe_cnt10", strobe_cnt, 10);
      chk("sample_count10", sample_count, 10);
      chk("antenna_word", antenna, pat(25));
      chk("strobe_ant", last_ant, pat(25));
      chk("lat_phase6", last_strobe_cyc, h_last + 10);

      // Period tolerance.
      run_period(11, 24'h111111);
      run_period(13, 24'h222222);
      run_period(12, 24'h333333);
      #1;
      chk("tol_locked", locked, 1);
      chk("tol_err", err_count, 0);
      run_period(14, 24'h444444);
      run_period(12, 24'h555555);
      #1;
      chk("p14_unlock", locked, 0);
      chk("p14_err", err_count, 1);

      // Short period during ACQUIRE clears the good count.
      for (int k = 0; k < 5; k++) run_period(12, pat(k));
      run_period(10, 24'h666666);
      for (int k = 0; k < 16; k++) run_period(12, pat(k));
      #1;
      chk("acq_reset_good", locked, 0);
      run_period(12, pat(0));
      #1;
      chk("acq_relock", locked, 1);

      // Missing edge: per reaches 13 at h+16, locked falls at h+17.
      run_period(12, 24'h777777);
      hl = h_last;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk_x);
         rx_clk = 1'b0;
         if (cyc == hl + 16) l16 = locked;
         if (cyc == hl + 17) begin
            l17 = locked;
            e17 = err_count;
         end
      end
      chk("tout_before", l16, 1);
      chk("tout_fall", l17, 0);
      chk("tout_err", e17, 2);
      for (int k = 0; k < 17; k++) run_period(12, pat(k));
      #1;
      chk("tout_relock", locked, 1);

      // Enable gating over 50 cycles.
      sc0 = sample_count;
      st0 = strobe_cnt;
      enable = 1'b0;
      run_period(12, 24'h123456);
      run_period(13, 24'h654321);
      run_period(13, 24'h0F0F0F);
      run_period(12, 24'hF0F0F0);
      #1;
      chk("en_no_strobe", strobe_cnt, st0);
      chk("en_count_frz", sample_count, sc0);
      chk("en_locked", locked, 1);
      chk("en_antenna", antenna, 24'hF0F0F0);
      enable = 1'b1;
      run_period(12, 24'h0000AA);
      #1;
      chk("en_resume", strobe_cnt, st0 + 1);
      chk("en_count", sample_count, sc0 + 1);

      // Phase clamp and latency.
      phase = 4'd0;
      run_period(12, 24'hC0FFEE);
      run_period(12, 24'hBEEF01);
      #1;
      chk("lat_phase0", last_strobe_cyc, h_last + 4);
      chk("ant_phase0", last_ant, 24'hBEEF01);
      phase = 4'd11;
      run_period(13, 24'h010101);
      run_period(13, 24'h020202);
      run_period(13, 24'h030303);
      #1;
      chk("lat_phase11", last_strobe_cyc, h_prev + 15);
      chk("ant_phase11", last_ant, 24'h020202);
      phase = 4'd15;
      run_period(13, 24'h040404);
      run_period(13, 24'h050505);
      run_period(13, 24'h060606);
      #1;
      chk("lat_phase15", last_strobe_cyc, h_prev + 15);
      chk("ant_phase15", last_ant, 24'h050505);

      // Reset while locked.
      phase = 4'd6;
      run_period(12, 24'hABCDEF);
      run_period(12, 24'hFEDCBA);
      #1;
      chk("pre_rst_locked", locked, 1);
      chk("pre_rst_err", err_count, 2);
      @(negedge clk_x);
      rst = 1'b1;
      @(negedge clk_x);
      chk("mid_rst_strobe", strobe, 0);
      chk("mid_rst_antenna", antenna, 0);
      chk("mid_rst_locked", locked, 0);
      chk("mid_rst_count", sample_count, 0);
      chk("mid_rst_err", err_count, 0);
      rst = 1'b0;

      // 300 losses of lock: 17 x 11-cycle periods then a 10-cycle one.
      for (int it = 0; it < 300; it++) begin
         for (int p = 0; p < 17; p++) run_period(11, pat(p));
         run_period(10, 24'h0);
         if (it == 254) begin
            #1;
            chk("err_254", err_count, 254);
         end
      end
      run_period(11, 24'h0);
      #1;
      chk("err_sat", err_count, 255);
      chk("sat_unlocked", locked, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
